// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: PC source selects,
// forwarding selects and the interrupt FSM state type.
package pipe_ctrl_pkg;
  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_JMP = 2'd2;
  localparam logic [1:0] PCSEL_IRQ = 2'd3;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  typedef enum logic [1:0] {RUN, WAIT, TAKE, MASKED} state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: pipeline side, slave: hazard controller.
// HAZARD_PERF_CNT_EN adds the LuStallCnt / FlushCnt counter outputs.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW  = 5,
  parameter int PCSEL_W = 2
);
  logic              MemRead_ex;
  logic [REG_AW-1:0] RtAddr_ex;
  logic [REG_AW-1:0] RsAddr_ex;
  logic [REG_AW-1:0] RsAddr_id;
  logic [REG_AW-1:0] RtAddr_id;
  logic              BranchTaken_ex;
  logic              Jump_id;
  logic              Eret_id;
  logic              IRQ;
  logic              RegWrite_mem;
  logic [REG_AW-1:0] WrAddr_mem;
  logic              RegWrite_wb;
  logic [REG_AW-1:0] WrAddr_wb;
  logic              Stall_pc;
  logic              Stall_ifid;
  logic              Flush_ifid;
  logic              Bubble_idex;
  logic [PCSEL_W-1:0] PC_sel;
  logic              IRQ_take;
  logic [1:0]        ForwardA;
  logic [1:0]        ForwardB;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]       LuStallCnt;
  logic [31:0]       FlushCnt;
`endif

  modport master (
    output MemRead_ex, RtAddr_ex, RsAddr_ex, RsAddr_id, RtAddr_id,
           BranchTaken_ex, Jump_id, Eret_id, IRQ,
           RegWrite_mem, WrAddr_mem, RegWrite_wb, WrAddr_wb,
`ifdef HAZARD_PERF_CNT_EN
    input  LuStallCnt, FlushCnt,
`endif
    input  Stall_pc, Stall_ifid, Flush_ifid, Bubble_idex, PC_sel, IRQ_take,
           ForwardA, ForwardB
  );

  modport slave (
    input  MemRead_ex, RtAddr_ex, RsAddr_ex, RsAddr_id, RtAddr_id,
           BranchTaken_ex, Jump_id, Eret_id, IRQ,
           RegWrite_mem, WrAddr_mem, RegWrite_wb, WrAddr_wb,
`ifdef HAZARD_PERF_CNT_EN
    output LuStallCnt, FlushCnt,
`endif
    output Stall_pc, Stall_ifid, Flush_ifid, Bubble_idex, PC_sel, IRQ_take,
           ForwardA, ForwardB
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage forwarding compare for one source operand. MEM beats WB since it
// holds the younger result; register 0 is never forwarded.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              we_mem,
  input  logic [REG_AW-1:0] addr_mem,
  input  logic              we_wb,
  input  logic [REG_AW-1:0] addr_wb,
  output logic [1:0]        sel
);
  // priority select MEM > WB > regfile
  always_comb begin
    sel = FWD_RF;
    if (we_mem && addr_mem != '0 && addr_mem == src)   sel = FWD_MEM;
    else if (we_wb && addr_wb != '0 && addr_wb == src) sel = FWD_WB;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stall,
// branch/jump flush, EX forwarding selects and the interrupt FSM.
// Optional perf counters under HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int PCSEL_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  pipe_hazard_ctrl_if.slave bus
);
  state_t             state;
  logic               lu, br;
  logic [1:0]         fwd_a, fwd_b;
  logic               stall, flush, bubble, take;
  logic [PCSEL_W-1:0] pc_sel;
  logic [1:0]         fa, fb;

  assign br = bus.BranchTaken_ex;
  assign lu = bus.MemRead_ex && (bus.RtAddr_ex != '0) &&
              (bus.RtAddr_ex == bus.RsAddr_id || bus.RtAddr_ex == bus.RtAddr_id);

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .src(bus.RsAddr_ex), .we_mem(bus.RegWrite_mem), .addr_mem(bus.WrAddr_mem),
    .we_wb(bus.RegWrite_wb), .addr_wb(bus.WrAddr_wb), .sel(fwd_a)
  );
  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .src(bus.RtAddr_ex), .we_mem(bus.RegWrite_mem), .addr_mem(bus.WrAddr_mem),
    .we_wb(bus.RegWrite_wb), .addr_wb(bus.WrAddr_wb), .sel(fwd_b)
  );

  // interrupt FSM: wait out control hazards, vector once, mask until ERET
  always_ff @(posedge clk) begin
    if (!reset) state <= RUN;
    else begin
      case (state)
        RUN:    if (bus.IRQ) state <= (br || lu) ? WAIT : TAKE;
        WAIT:   if (!bus.IRQ) state <= RUN;
                else if (!br && !lu) state <= TAKE;
        TAKE:   state <= MASKED;
        MASKED: if (bus.Eret_id && !lu && !br) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // control outputs, priority reset > TAKE > branch > load-use > jump
  always_comb begin
    stall  = 1'b0;
    flush  = 1'b0;
    bubble = 1'b0;
    take   = 1'b0;
    pc_sel = PCSEL_W'(PCSEL_SEQ);
    fa     = FWD_RF;
    fb     = FWD_RF;
    if (!reset) begin
      flush  = 1'b1;
      bubble = 1'b1;
    end else begin
      fa = fwd_a;
      fb = fwd_b;
      if (state == TAKE) begin
        take   = 1'b1;
        flush  = 1'b1;
        bubble = 1'b1;
        pc_sel = PCSEL_W'(PCSEL_IRQ);
      end else if (br) begin
        // the stalled instruction is squashed, so no stall here
        flush  = 1'b1;
        bubble = 1'b1;
        pc_sel = PCSEL_W'(PCSEL_BR);
      end else if (lu) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end else if (bus.Jump_id) begin
        flush  = 1'b1;
        pc_sel = PCSEL_W'(PCSEL_JMP);
      end
    end
  end

  assign bus.Stall_pc    = stall;
  assign bus.Stall_ifid  = stall;
  assign bus.Flush_ifid  = flush;
  assign bus.Bubble_idex = bubble;
  assign bus.PC_sel      = pc_sel;
  assign bus.IRQ_take    = take;
  assign bus.ForwardA    = fa;
  assign bus.ForwardB    = fb;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt, flush_cnt;

  // free-running event counters, wrap naturally at 2^32
  always_ff @(posedge clk) begin
    if (!reset) begin
      lu_cnt    <= '0;
      flush_cnt <= '0;
    end else begin
      if (lu)    lu_cnt    <= lu_cnt + 32'd1;
      if (flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign bus.LuStallCnt = lu_cnt;
  assign bus.FlushCnt   = flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Counter checks compile in when
// HAZARD_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   fails;

  pipe_hazard_ctrl_if #(.REG_AW(5), .PCSEL_W(2)) bus ();

  pipe_hazard_ctrl #(.REG_AW(5), .PCSEL_W(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.MemRead_ex = 0; bus.RtAddr_ex = 0; bus.RsAddr_ex = 0;
    bus.RsAddr_id = 0; bus.RtAddr_id = 0; bus.BranchTaken_ex = 0;
    bus.Jump_id = 0; bus.Eret_id = 0; bus.IRQ = 0;
    bus.RegWrite_mem = 0; bus.WrAddr_mem = 0; bus.RegWrite_wb = 0; bus.WrAddr_wb = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    idle();
    bus.BranchTaken_ex = 1; bus.Jump_id = 1;
    bus.RegWrite_mem = 1; bus.WrAddr_mem = 3; bus.RsAddr_ex = 3;
    #1;
    checks++; if (bus.Bubble_idex !== 1'b1) begin fails++; $display("FAIL rst_bubble got=%0d exp=1", bus.Bubble_idex); end
    checks++; if (bus.Flush_ifid !== 1'b1) begin fails++; $display("FAIL rst_flush got=%0d exp=1", bus.Flush_ifid); end
    checks++; if (bus.PC_sel !== 2'd0) begin fails++; $display("FAIL rst_pcsel got=%0d exp=0", bus.PC_sel); end
    checks++; if (bus.ForwardA !== 2'd0) begin fails++; $display("FAIL rst_fwda got=%0d exp=0", bus.ForwardA); end
    checks++; if (bus.Stall_pc !== 1'b0) begin fails++; $display("FAIL rst_stall got=%0d exp=0", bus.Stall_pc); end
    tick();
    tick();
    checks++; if (dut.state !== RUN) begin fails++; $display("FAIL rst_state got=%0d exp=%0d", dut.state, RUN); end
    idle();
    reset = 1;
    #1;
    checks++; if ({bus.Stall_pc, bus.Flush_ifid, bus.Bubble_idex, bus.IRQ_take, bus.PC_sel} !== 6'b0)
      begin fails++; $display("FAIL idle_ctrl got=%b exp=000000", {bus.Stall_pc, bus.Flush_ifid, bus.Bubble_idex, bus.IRQ_take, bus.PC_sel}); end
  endtask

  task automatic test_load_use();
    bus.MemRead_ex = 1; bus.RtAddr_ex = 8; bus.RsAddr_id = 8;
    #1;
    checks++; if ({bus.Stall_pc, bus.Stall_ifid, bus.Bubble_idex} !== 3'b111) begin fails++; $display("FAIL lu_ctrl got=%b exp=111", {bus.Stall_pc, bus.Stall_ifid, bus.Bubble_idex}); end
    checks++; if (bus.PC_sel !== 2'd0 || bus.Flush_ifid !== 1'b0) begin fails++; $display("FAIL lu_pcsel got=%0d/%0d exp=0/0", bus.PC_sel, bus.Flush_ifid); end
    bus.Jump_id = 1;  // jump waits behind the stall
    #1;
    checks++; if (bus.PC_sel !== 2'd0 || bus.Stall_pc !== 1'b1) begin fails++; $display("FAIL lu_jump got=%0d/%0d exp=0/1", bus.PC_sel, bus.Stall_pc); end
    tick();
    bus.MemRead_ex = 0; bus.Jump_id = 0;
    #1;
    checks++; if ({bus.Stall_pc, bus.Stall_ifid, bus.Bubble_idex, bus.Flush_ifid, bus.PC_sel} !== 6'b0) begin fails++; $display("FAIL lu_after got=%b exp=000000", {bus.Stall_pc, bus.Stall_ifid, bus.Bubble_idex, bus.Flush_ifid, bus.PC_sel}); end
    // load to r0 never stalls, rt-side match does
    bus.MemRead_ex = 1; bus.RtAddr_ex = 0; bus.RsAddr_id = 0;
    #1;
    checks++; if (bus.Stall_pc !== 1'b0) begin fails++; $display("FAIL lu_r0 got=%0d exp=0", bus.Stall_pc); end
    bus.RtAddr_ex = 12; bus.RtAddr_id = 12;
    #1;
    checks++; if (bus.Stall_ifid !== 1'b1) begin fails++; $display("FAIL lu_rt got=%0d exp=1", bus.Stall_ifid); end
    tick();
    idle();
  endtask

  task automatic test_branch_over_lu();
    bus.MemRead_ex = 1; bus.RtAddr_ex = 8; bus.RsAddr_id = 8; bus.BranchTaken_ex = 1;
    #1;
    checks++; if ({bus.Flush_ifid, bus.Bubble_idex} !== 2'b11) begin fails++; $display("FAIL br_flush got=%b exp=11", {bus.Flush_ifid, bus.Bubble_idex}); end
    checks++; if (bus.PC_sel !== 2'd1) begin fails++; $display("FAIL br_pcsel got=%0d exp=1", bus.PC_sel); end
    checks++; if ({bus.Stall_pc, bus.Stall_ifid} !== 2'b00) begin fails++; $display("FAIL br_stall got=%b exp=00", {bus.Stall_pc, bus.Stall_ifid}); end
    tick();
    idle();
  endtask

  task automatic test_jump();
    bus.Jump_id = 1;
    #1;
    checks++; if (bus.PC_sel !== 2'd2 || bus.Flush_ifid !== 1'b1 || bus.Bubble_idex !== 1'b0) begin fails++; $display("FAIL jp got=%0d/%0d/%0d exp=2/1/0", bus.PC_sel, bus.Flush_ifid, bus.Bubble_idex); end
    tick();
    idle();
  endtask

  task automatic test_forwarding();
    bus.RegWrite_mem = 1; bus.WrAddr_mem = 5; bus.RegWrite_wb = 1; bus.WrAddr_wb = 5; bus.RsAddr_ex = 5;
    #1;
    checks++; if (bus.ForwardA !== 2'd2) begin fails++; $display("FAIL fwd_mem got=%0d exp=2", bus.ForwardA); end
    bus.WrAddr_mem = 0;
    #1;
    checks++; if (bus.ForwardA !== 2'd1) begin fails++; $display("FAIL fwd_wb got=%0d exp=1", bus.ForwardA); end
    bus.RtAddr_ex = 0; bus.WrAddr_wb = 0;
    #1;
    checks++; if (bus.ForwardB !== 2'd0) begin fails++; $display("FAIL fwd_r0 got=%0d exp=0", bus.ForwardB); end
    bus.WrAddr_mem = 9; bus.RtAddr_ex = 9; bus.RegWrite_mem = 1;
    #1;
    checks++; if (bus.ForwardB !== 2'd2 || bus.ForwardA !== 2'd0) begin fails++; $display("FAIL fwd_b_mem got=%0d/%0d exp=2/0", bus.ForwardB, bus.ForwardA); end
    bus.RegWrite_mem = 0;
    #1;
    checks++; if (bus.ForwardB !== 2'd0) begin fails++; $display("FAIL fwd_nowe got=%0d exp=0", bus.ForwardB); end
    tick();
    idle();
  endtask

  task automatic test_irq_branch();
    bus.IRQ = 1; bus.BranchTaken_ex = 1;
    #1;
    checks++; if (bus.PC_sel !== 2'd1 || bus.IRQ_take !== 1'b0) begin fails++; $display("FAIL irqbr_pcsel got=%0d/%0d exp=1/0", bus.PC_sel, bus.IRQ_take); end
    tick();
    checks++; if (dut.state !== WAIT) begin fails++; $display("FAIL irqbr_wait got=%0d exp=%0d", dut.state, WAIT); end
    bus.BranchTaken_ex = 0;
    #1;
    checks++; if (bus.IRQ_take !== 1'b0 || bus.PC_sel !== 2'd0) begin fails++; $display("FAIL wait_quiet got=%0d/%0d exp=0/0", bus.IRQ_take, bus.PC_sel); end
    tick();
    // load-use during TAKE must not stall
    bus.MemRead_ex = 1; bus.RtAddr_ex = 8; bus.RsAddr_id = 8;
    #1;
    checks++; if (bus.IRQ_take !== 1'b1 || bus.PC_sel !== 2'd3) begin fails++; $display("FAIL take got=%0d/%0d exp=1/3", bus.IRQ_take, bus.PC_sel); end
    checks++; if ({bus.Flush_ifid, bus.Bubble_idex, bus.Stall_pc} !== 3'b110) begin fails++; $display("FAIL take_ctrl got=%b exp=110", {bus.Flush_ifid, bus.Bubble_idex, bus.Stall_pc}); end
    tick();
    bus.MemRead_ex = 0;
    #1;
    checks++; if (dut.state !== MASKED || bus.IRQ_take !== 1'b0) begin fails++; $display("FAIL masked got=%0d/%0d exp=%0d/0", dut.state, bus.IRQ_take, MASKED); end
  endtask

  task automatic test_masking();
    int seen;
    seen = 0;
    bus.IRQ = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.IRQ_take !== 1'b0) seen++;
      tick();
    end
    checks++; if (seen !== 0 || dut.state !== MASKED) begin fails++; $display("FAIL mask_hold takes=%0d state=%0d exp=0/%0d", seen, dut.state, MASKED); end
    // ERET blocked by a load-use stall
    bus.Eret_id = 1; bus.MemRead_ex = 1; bus.RtAddr_ex = 4; bus.RtAddr_id = 4;
    tick();
    checks++; if (dut.state !== MASKED) begin fails++; $display("FAIL eret_lu got=%0d exp=%0d", dut.state, MASKED); end
    bus.MemRead_ex = 0;
    tick();
    bus.Eret_id = 0;
    #1;
    checks++; if (dut.state !== RUN || bus.IRQ_take !== 1'b0) begin fails++; $display("FAIL eret_run got=%0d/%0d exp=%0d/0", dut.state, bus.IRQ_take, RUN); end
    tick();
    checks++; if (bus.IRQ_take !== 1'b1 || bus.PC_sel !== 2'd3) begin fails++; $display("FAIL retake got=%0d/%0d exp=1/3", bus.IRQ_take, bus.PC_sel); end
    tick();
    bus.IRQ = 0; bus.Eret_id = 1;
    tick();
    idle();
    #1;
    checks++; if (dut.state !== RUN) begin fails++; $display("FAIL mask_exit got=%0d exp=%0d", dut.state, RUN); end
  endtask

  task automatic test_reset_mid_wait();
    bus.IRQ = 1; bus.BranchTaken_ex = 1;
    tick();
    checks++; if (dut.state !== WAIT) begin fails++; $display("FAIL rw_wait got=%0d exp=%0d", dut.state, WAIT); end
    reset = 0; bus.BranchTaken_ex = 0;
    #1;
    checks++; if ({bus.Bubble_idex, bus.Flush_ifid, bus.IRQ_take} !== 3'b110) begin fails++; $display("FAIL rw_forced got=%b exp=110", {bus.Bubble_idex, bus.Flush_ifid, bus.IRQ_take}); end
    tick();
    reset = 1;
    #1;
    checks++; if (dut.state !== RUN || bus.IRQ_take !== 1'b0) begin fails++; $display("FAIL rw_run got=%0d/%0d exp=%0d/0", dut.state, bus.IRQ_take, RUN); end
`ifdef HAZARD_PERF_CNT_EN
    checks++; if (bus.LuStallCnt !== 32'd0 || bus.FlushCnt !== 32'd0) begin fails++; $display("FAIL rw_cnt got=%0d/%0d exp=0/0", bus.LuStallCnt, bus.FlushCnt); end
`endif
    tick();
    checks++; if (bus.IRQ_take !== 1'b1) begin fails++; $display("FAIL rw_take got=%0d exp=1", bus.IRQ_take); end
    tick();
    bus.IRQ = 0; bus.Eret_id = 1;
    tick();
    idle();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    reset = 0;
    tick();
    reset = 1;
    bus.MemRead_ex = 1; bus.RtAddr_ex = 8; bus.RsAddr_id = 8;
    tick();
    bus.BranchTaken_ex = 1;
    tick();
    idle();
    #1;
    checks++; if (bus.LuStallCnt !== 32'd2 || bus.FlushCnt !== 32'd1) begin fails++; $display("FAIL perf1 got=%0d/%0d exp=2/1", bus.LuStallCnt, bus.FlushCnt); end
    bus.Jump_id = 1;
    tick();
    idle();
    #1;
    checks++; if (bus.LuStallCnt !== 32'd2 || bus.FlushCnt !== 32'd2) begin fails++; $display("FAIL perf2 got=%0d/%0d exp=2/2", bus.LuStallCnt, bus.FlushCnt); end
  endtask
`endif

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 0;
    idle();
    test_reset();
    test_load_use();
    test_branch_over_lu();
    test_jump();
    test_forwarding();
    test_irq_branch();
    test_masking();
    test_reset_mid_wait();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
